// File: rtl/breath_ramp.sv
// Breathing-LED duty sequencer for zPWM: rise, hold high, fall, hold low, stepping only on period_end.
// Optional BRL_GAMMA_EN: duty = (level*level) >> DW instead of duty = level.
module breath_ramp #(
    parameter int unsigned DW           = 8,
    parameter int unsigned MAX_LEVEL    = 255,
    parameter int unsigned STEP_DIV     = 16,
    parameter int unsigned HOLD_PERIODS = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          period_end,
    output logic [DW-1:0] duty,
    output logic          pwm_en,
    output logic [2:0]    phase,
    output logic          cycle_done
);

    localparam int unsigned SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int unsigned HW = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;

    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);
    localparam logic [SW-1:0] STEP_ONE  = SW'(1);
    localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_PERIODS == 0) ? 0 : HOLD_PERIODS - 1);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
    localparam logic [DW-1:0] LVL_TOP   = DW'(MAX_LEVEL);
    localparam logic [DW-1:0] LVL_PRE   = DW'(MAX_LEVEL - 1);
    localparam logic [DW-1:0] LVL_ONE   = DW'(1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RISE    = 3'd1;
    localparam logic [2:0] HOLD_HI = 3'd2;
    localparam logic [2:0] FALL    = 3'd3;
    localparam logic [2:0] HOLD_LO = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [DW-1:0] level_q, level_d;
    logic [SW-1:0] step_cnt_q, step_cnt_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [DW-1:0] duty_q, duty_d;
    logic          pwm_en_q, pwm_en_d;
    logic          cycle_done_q, cycle_done_d;
    logic          step_due;

    assign step_due = period_end && (step_cnt_q == STEP_LAST);

    always_comb begin
        state_d      = state_q;
        level_d      = level_q;
        step_cnt_d   = step_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        pwm_en_d     = pwm_en_q;
        cycle_done_d = 1'b0;
        if (!en) begin
            // Dropping en wins over any coincident period_end.
            state_d    = IDLE;
            level_d    = '0;
            step_cnt_d = '0;
            hold_cnt_d = '0;
            pwm_en_d   = 1'b0;
        end else begin
            pwm_en_d = 1'b1;
            case (state_q)
                IDLE: begin
                    state_d    = RISE;
                    level_d    = '0;
                    step_cnt_d = '0;
                    hold_cnt_d = '0;
                end
                RISE: begin
                    if (step_due) begin
                        step_cnt_d = '0;
                        if (level_q < LVL_TOP) begin
                            level_d = level_q + LVL_ONE;
                        end
                        if (level_q >= LVL_PRE) begin
                            state_d = (HOLD_PERIODS == 0) ? FALL : HOLD_HI;
                        end
                    end else if (period_end) begin
                        step_cnt_d = step_cnt_q + STEP_ONE;
                    end
                end
                HOLD_HI: begin
                    if (period_end) begin
                        if (hold_cnt_q == HOLD_LAST) begin
                            hold_cnt_d = '0;
                            state_d    = FALL;
                        end else begin
                            hold_cnt_d = hold_cnt_q + HOLD_ONE;
                        end
                    end
                end
                FALL: begin
                    if (step_due) begin
                        step_cnt_d = '0;
                        if (level_q != '0) begin
                            level_d = level_q - LVL_ONE;
                        end
                        if (level_q <= LVL_ONE) begin
                            if (HOLD_PERIODS == 0) begin
                                state_d      = RISE;
                                cycle_done_d = 1'b1;
                            end else begin
                                state_d = HOLD_LO;
                            end
                        end
                    end else if (period_end) begin
                        step_cnt_d = step_cnt_q + STEP_ONE;
                    end
                end
                HOLD_LO: begin
                    if (period_end) begin
                        if (hold_cnt_q == HOLD_LAST) begin
                            hold_cnt_d   = '0;
                            state_d      = RISE;
                            cycle_done_d = 1'b1;
                        end else begin
                            hold_cnt_d = hold_cnt_q + HOLD_ONE;
                        end
                    end
                end
                default: begin
                    state_d    = IDLE;
                    level_d    = '0;
                    step_cnt_d = '0;
                    hold_cnt_d = '0;
                end
            endcase
        end
    end

    // Duty is derived from the next level so it lands on the same edge as the step.
`ifdef BRL_GAMMA_EN
    logic [2*DW-1:0] gamma_prod;
    always_comb begin
        gamma_prod = {{DW{1'b0}}, level_d} * {{DW{1'b0}}, level_d};
        duty_d     = gamma_prod[2*DW-1:DW];
    end
`else
    always_comb begin
        duty_d = level_d;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            level_q      <= '0;
            step_cnt_q   <= '0;
            hold_cnt_q   <= '0;
            duty_q       <= '0;
            pwm_en_q     <= 1'b0;
            cycle_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            step_cnt_q   <= step_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            duty_q       <= duty_d;
            pwm_en_q     <= pwm_en_d;
            cycle_done_q <= cycle_done_d;
        end
    end

    assign duty       = duty_q;
    assign pwm_en     = pwm_en_q;
    assign phase      = state_q;
    assign cycle_done = cycle_done_q;

endmodule

// File: tb/tb_breath_ramp.sv
// Directed bench for breath_ramp: three instances cover hold, no-hold and full-range configs.
module tb_breath_ramp;

    logic       clk = 1'b0;
    logic       rst;
    logic       en_a, pe_a, en_b, pe_b, en_c, pe_c;
    logic [7:0] duty_a, duty_b, duty_c;
    logic       pwm_en_a, pwm_en_b, pwm_en_c;
    logic [2:0] phase_a, phase_b, phase_c;
    logic       done_a, done_b, done_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    breath_ramp #(.DW(8), .MAX_LEVEL(4), .STEP_DIV(2), .HOLD_PERIODS(3)) dut_a (
        .clk(clk), .rst(rst), .en(en_a), .period_end(pe_a),
        .duty(duty_a), .pwm_en(pwm_en_a), .phase(phase_a), .cycle_done(done_a)
    );

    breath_ramp #(.DW(8), .MAX_LEVEL(2), .STEP_DIV(1), .HOLD_PERIODS(0)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .period_end(pe_b),
        .duty(duty_b), .pwm_en(pwm_en_b), .phase(phase_b), .cycle_done(done_b)
    );

    breath_ramp #(.DW(8), .MAX_LEVEL(255), .STEP_DIV(1), .HOLD_PERIODS(0)) dut_c (
        .clk(clk), .rst(rst), .en(en_c), .period_end(pe_c),
        .duty(duty_c), .pwm_en(pwm_en_c), .phase(phase_c), .cycle_done(done_c)
    );

    function automatic logic [7:0] exp_duty(input int lvl);
`ifdef BRL_GAMMA_EN
        return 8'((lvl * lvl) >> 8);
`else
        return 8'(lvl);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One PWM period of 8 clocks on dut_a, period_end in the last one.
    task automatic period_a();
        repeat (7) tick();
        pe_a = 1'b1;
        tick();
        pe_a = 1'b0;
    endtask

    task automatic period_b();
        repeat (3) tick();
        pe_b = 1'b1;
        tick();
        pe_b = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en_a = 1'b0; pe_a = 1'b0;
        en_b = 1'b0; pe_b = 1'b0;
        en_c = 1'b0; pe_c = 1'b0;
        repeat (2) tick();
        checks++;
        if (duty_a !== 8'd0 || pwm_en_a !== 1'b0 || phase_a !== 3'd0 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: duty=%0d pwm_en=%b phase=%0d done=%b, want 0 0 0 0",
                     duty_a, pwm_en_a, phase_a, done_a);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        en_a = 1'b1;
        tick();
        repeat (6) period_a();
        checks++;
        if (duty_a !== exp_duty(3) || phase_a !== 3'd1) begin
            errors++;
            $display("FAIL pre_reset_level: duty=%0d phase=%0d, want %0d 1",
                     duty_a, phase_a, exp_duty(3));
        end
        rst = 1'b1;
        #1;
        checks++;
        if (duty_a !== 8'd0 || pwm_en_a !== 1'b0 || phase_a !== 3'd0) begin
            errors++;
            $display("FAIL async_reset: duty=%0d pwm_en=%b phase=%0d, want 0 0 0",
                     duty_a, pwm_en_a, phase_a);
        end
        en_a = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_full_breath();
        logic [2:0] lvl_tab [22] = '{0, 1, 1, 2, 2, 3, 3, 4, 4, 4, 4,
                                     4, 3, 3, 2, 2, 1, 1, 0, 0, 0, 0};
        logic [2:0] ph_tab  [22] = '{1, 1, 1, 1, 1, 1, 1, 2, 2, 2, 3,
                                     3, 3, 3, 3, 3, 3, 3, 4, 4, 4, 1};
        int done_cnt = 0;
        en_a = 1'b1;
        tick();
        checks++;
        if (phase_a !== 3'd1 || pwm_en_a !== 1'b1 || duty_a !== 8'd0 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL idle_to_rise: phase=%0d pwm_en=%b duty=%0d done=%b, want 1 1 0 0",
                     phase_a, pwm_en_a, duty_a, done_a);
        end
        for (int i = 0; i < 22; i++) begin
            period_a();
            if (done_a === 1'b1) done_cnt++;
            checks++;
            if (duty_a !== exp_duty(int'(lvl_tab[i])) || phase_a !== ph_tab[i]) begin
                errors++;
                $display("FAIL breath_step%0d: duty=%0d phase=%0d, want %0d %0d", i + 1,
                         duty_a, phase_a, exp_duty(int'(lvl_tab[i])), ph_tab[i]);
            end
        end
        checks++;
        if (done_cnt !== 1 || done_a !== 1'b1) begin
            errors++;
            $display("FAIL cycle_done_pulse: count=%0d now=%b, want 1 1", done_cnt, done_a);
        end
        tick();
        checks++;
        if (done_a !== 1'b0) begin
            errors++;
            $display("FAIL cycle_done_width: done=%b, want 0", done_a);
        end
        en_a = 1'b0;
        tick();
    endtask

    task automatic test_no_hold();
        logic [1:0] lvl_tab [6] = '{1, 2, 1, 0, 1, 2};
        logic [2:0] ph_tab  [6] = '{1, 3, 3, 1, 1, 3};
        logic       dn_tab  [6] = '{0, 0, 0, 1, 0, 0};
        en_b = 1'b1;
        tick();
        checks++;
        if (duty_b !== 8'd0 || phase_b !== 3'd1) begin
            errors++;
            $display("FAIL no_hold_start: duty=%0d phase=%0d, want 0 1", duty_b, phase_b);
        end
        for (int i = 0; i < 6; i++) begin
            period_b();
            checks++;
            if (duty_b !== 8'(lvl_tab[i]) || phase_b !== ph_tab[i] || done_b !== dn_tab[i]) begin
                errors++;
                $display("FAIL no_hold_step%0d: duty=%0d phase=%0d done=%b, want %0d %0d %b",
                         i + 1, duty_b, phase_b, done_b, lvl_tab[i], ph_tab[i], dn_tab[i]);
            end
        end
        en_b = 1'b0;
        tick();
    endtask

    task automatic test_en_drop();
        en_a = 1'b1;
        tick();
        repeat (5) period_a();
        checks++;
        if (duty_a !== exp_duty(2) || phase_a !== 3'd1) begin
            errors++;
            $display("FAIL en_drop_setup: duty=%0d phase=%0d, want %0d 1",
                     duty_a, phase_a, exp_duty(2));
        end
        en_a = 1'b0;
        pe_a = 1'b1;
        tick();
        pe_a = 1'b0;
        checks++;
        if (phase_a !== 3'd0 || duty_a !== 8'd0 || pwm_en_a !== 1'b0) begin
            errors++;
            $display("FAIL en_drop: phase=%0d duty=%0d pwm_en=%b, want 0 0 0",
                     phase_a, duty_a, pwm_en_a);
        end
        // Pulses while idle must not pre-load the step counter.
        repeat (3) begin
            pe_a = 1'b1;
            tick();
            pe_a = 1'b0;
            tick();
        end
        en_a = 1'b1;
        tick();
        period_a();
        checks++;
        if (duty_a !== 8'd0 || phase_a !== 3'd1) begin
            errors++;
            $display("FAIL idle_counter_clear: duty=%0d phase=%0d, want 0 1", duty_a, phase_a);
        end
        period_a();
        checks++;
        if (duty_a !== exp_duty(1)) begin
            errors++;
            $display("FAIL restart_step: duty=%0d, want %0d", duty_a, exp_duty(1));
        end
        en_a = 1'b0;
        tick();
    endtask

    task automatic test_latency();
        en_b = 1'b1;
        tick();
        repeat (3) tick();
        pe_b = 1'b1;
        #3;
        checks++;
        if (duty_b !== 8'd0) begin
            errors++;
            $display("FAIL latency_early: duty=%0d, want 0", duty_b);
        end
        tick();
        pe_b = 1'b0;
        checks++;
        if (duty_b !== 8'd1) begin
            errors++;
            $display("FAIL latency_edge: duty=%0d, want 1", duty_b);
        end
        en_b = 1'b0;
        tick();
    endtask

    task automatic test_full_range();
        logic [7:0] max_seen = 8'd0;
        en_c = 1'b1;
        tick();
        pe_c = 1'b1;
        for (int i = 1; i <= 255; i++) begin
            tick();
            if (duty_c > max_seen) max_seen = duty_c;
            if (i == 128) begin
                checks++;
                if (duty_c !== exp_duty(128)) begin
                    errors++;
                    $display("FAIL mid_level: duty=%0d, want %0d", duty_c, exp_duty(128));
                end
            end
        end
        checks++;
        if (duty_c !== exp_duty(255) || phase_c !== 3'd3) begin
            errors++;
            $display("FAIL top_level: duty=%0d phase=%0d, want %0d 3",
                     duty_c, phase_c, exp_duty(255));
        end
        tick();
        checks++;
        if (max_seen !== exp_duty(255) || duty_c !== exp_duty(254)) begin
            errors++;
            $display("FAIL saturation: max=%0d duty=%0d, want %0d %0d",
                     max_seen, duty_c, exp_duty(255), exp_duty(254));
        end
        pe_c = 1'b0;
        en_c = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_async_reset();
        test_full_breath();
        test_no_hold();
        test_en_drop();
        test_latency();
        test_full_range();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
